// File: rtl/logic_unit_pkg.sv
// ----------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the logic_unit_arbiter slice:
//   - opcode constants for the shared 2-input bitwise gate evaluator
//   - FSM state encoding (IDLE / EXEC / DONE, 2 bits)
//   - logic_eval(): single-bit gate evaluation, replicated per bit by users
// ----------------------------------------------------------------------------
package logic_unit_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    // One bit of the gate datapath; callers apply it across the operand width.
    function automatic logic logic_eval(input logic [1:0] op, input logic a, input logic b);
        logic y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a & b);
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// ----------------------------------------------------------------------------
// logic_unit_arbiter_if
// Request and response handshake bundle of the shared logic unit.
//   req_valid/req_ready : per-requester request handshake (NREQ bits each)
//   req_op              : 2-bit opcode per requester, slice i at [2i+1:2i]
//   req_a/req_b         : WIDTH-bit operands per requester, slice i
//   rsp_valid/rsp_ready : single response handshake
//   rsp_id/rsp_y        : owning requester index and result
// modport master: requesters + response consumer; modport slave: the arbiter.
// ----------------------------------------------------------------------------
interface logic_unit_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 1
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_y;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y
    );

endinterface

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin search: the first set bit of req examined in the
// order ptr, ptr+1, ... wrapping modulo NREQ.
//   req       : request vector
//   ptr       : search start (always < NREQ)
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted bit
//   grant_any : at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    grant_any
);
    localparam int IDW = $clog2(NREQ);

    // Candidate index for each search position; one extra bit so ptr+gi can
    // exceed NREQ-1 before the single conditional wrap.
    logic [IDW:0]   sum  [NREQ];
    logic [IDW-1:0] cand [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign sum[gi]  = {1'b0, ptr} + (IDW+1)'(gi);
            assign cand[gi] = (sum[gi] >= (IDW+1)'(NREQ)) ?
                              IDW'(sum[gi] - (IDW+1)'(NREQ)) : sum[gi][IDW-1:0];
        end
    endgenerate

    // Scan from the farthest position back so the nearest hit wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                grant_idx = cand[k];
                grant_any = 1'b1;
            end
        end
        grant            = '0;
        grant[grant_idx] = grant_any;
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// ----------------------------------------------------------------------------
// logic_unit_arbiter
// Time-multiplexes one registered bitwise logic unit (AND/OR/XOR/NAND) among
// NREQ requesters with round-robin arbitration.
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   bus (slave) : request/response handshakes, see logic_unit_arbiter_if
//   busy        : high while an operation is in EXEC or DONE
//   grant_count : 16-bit saturating count of accepted requests, present only
//                 when LOGIC_UNIT_ARB_STATS_EN is defined
// Flow: IDLE (accept one request) -> EXEC (evaluate, register result)
//       -> DONE (hold response until rsp_ready) -> IDLE.
// ----------------------------------------------------------------------------
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_unit_arbiter_if.slave  bus,
    output logic                 busy
`ifdef LOGIC_UNIT_ARB_STATS_EN
    ,
    output logic [15:0]          grant_count
`endif
);
    localparam int IDW = $clog2(NREQ);

    state_e           state_reg, state_next;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [IDW-1:0]   id_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic [WIDTH-1:0] rsp_y_reg;
    logic [WIDTH-1:0] y_comb;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic [NREQ-1:0]  req_ready_c;
    logic             accept;
    logic             rsp_done;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // req_ready is masked during reset so nothing is accepted on a reset edge.
    always_comb begin
        state_next  = state_reg;
        req_ready_c = '0;
        accept      = 1'b0;
        rsp_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_any && !rst) begin
                    req_ready_c = grant;
                    accept      = 1'b1;
                    state_next  = EXEC;
                end
            end
            EXEC: state_next = DONE;
            DONE: begin
                if (bus.rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_eval
            assign y_comb[gi] = logic_eval(op_reg, a_reg[gi], b_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            op_reg     <= OP_AND;
            a_reg      <= '0;
            b_reg      <= '0;
            id_reg     <= '0;
            rsp_id_reg <= '0;
            rsp_y_reg  <= '0;
        end else begin
            if (accept) begin
                op_reg <= bus.req_op[2*grant_idx +: 2];
                a_reg  <= bus.req_a[WIDTH*grant_idx +: WIDTH];
                b_reg  <= bus.req_b[WIDTH*grant_idx +: WIDTH];
                id_reg <= grant_idx;
            end
            if (state_reg == EXEC) begin
                rsp_y_reg  <= y_comb;
                rsp_id_reg <= id_reg;
            end
            // Next search starts just past the requester that was served.
            if (rsp_done) begin
                rr_ptr_reg <= (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;
            end
        end
    end

`ifdef LOGIC_UNIT_ARB_STATS_EN
    logic [15:0] grant_count_reg;

    always_ff @(posedge clk) begin
        if (rst)                                    grant_count_reg <= '0;
        else if (accept && grant_count_reg != 16'hFFFF) grant_count_reg <= grant_count_reg + 16'd1;
    end

    assign grant_count = grant_count_reg;
`endif

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state_reg == DONE);
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_y     = rsp_y_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one registered 2-input bitwise logic unit (AND/OR/XOR/NAND) between NREQ requesters.
- Round-robin arbitration, valid/ready request handshake and valid/ready response handshake.
- Sits between gate-level test/stimulus sources and the single shared gate datapath, so several producers can time-multiplex one evaluator.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 1, operand/result width in bits.
- IDW, $clog2(NREQ), requester-id width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  one-hot accept pulse; at most one bit high.
- req_op  input  2*NREQ  opcode for requester i at bits [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 NAND.
- req_a  input  WIDTH*NREQ  operand a, slice i.
- req_b  input  WIDTH*NREQ  operand b, slice i.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  requester index owning the result.
- rsp_y  output  WIDTH  result.
- busy  output  1  high in EXEC or DONE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, busy=0.
  - rst has priority over every other event. An in-flight operation or pending response is dropped; no response is produced for it.
- FSM IDLE:
  - If any req_valid is set, grant the first set bit searching rr_ptr, rr_ptr+1, … wrapping modulo NREQ.
  - req_ready[g] is asserted combinationally in that same cycle. The transfer completes on that edge.
  - Latch op/a/b of g and id=g; go to EXEC.
  - If no req_valid is set, stay in IDLE; req_ready=0.
- FSM EXEC: compute rsp_y = op(a,b) bitwise on the latched operands and register it; rsp_id=g; go to DONE.
- FSM DONE:
  - rsp_valid=1; rsp_id and rsp_y held stable until the handshake.
  - On rsp_valid & rsp_ready: rr_ptr = (g+1) mod NREQ; go to IDLE; rsp_valid falls next cycle.
- Latency: request accept edge to rsp_valid = 2 cycles. Minimum issue interval = 3 cycles (accept, EXEC, DONE with rsp_ready=1).
- req_ready is only ever asserted in IDLE. Requests arriving in EXEC/DONE wait; requesters must hold valid and operands until ready.
- A requester that drops req_valid before being granted simply loses its turn; it is not an error.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,…,NREQ-1,0. No requester waits more than NREQ-1 grants.
- rr_ptr wraps from NREQ-1 to 0. When NREQ is not a power of 2, pointer values ≥NREQ are never produced.
- NAND = ~(a&b) across all WIDTH bits.

Optional Feature:
- Macro LOGIC_UNIT_ARB_STATS_EN.
- When defined, adds output port grant_count (16 bits):
  - Increments on every accepted request.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- When undefined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package logic_unit_pkg holds:
  - Opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11.
  - State encoding IDLE/EXEC/DONE (2-bit).
  - Function logic_eval(op,a,b).
- One natural sub-module, rr_arbiter (NREQ-wide priority search from rr_ptr; outputs a one-hot grant and a grant index). It is combinational; the pointer register stays in the parent.

Test Plan:
- Reset mid-DONE:
  - Stimulus: req 1 sent, rsp_ready=0, then rst for 1 cycle.
  - Required: rsp_valid=0, busy=0, rsp_y=0 the next cycle; a fresh request from requester 0 is granted first.
- Single requester, full opcode sweep:
  - Stimulus: requester 2 steps {a,b}=0..3 for each op, with WIDTH=1 and rsp_ready=1.
  - Required: truth tables AND 0001, OR 0111, XOR 0110, NAND 1110; rsp_id=2; rsp_valid exactly 2 cycles after each req_ready.
- Round-robin:
  - Stimulus: all four req_valid held high for 8 grants.
  - Required: grant order 0,1,2,3,0,1,2,3; req_ready is one-hot each time.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles in DONE.
  - Required: rsp_y/rsp_id stable; req_ready=0 on all bits; release yields exactly one response.
- Skip and wrap:
  - Stimulus: rr_ptr=3 after a grant to 2, with only req_valid[1] set.
  - Required: grant to 1; next pointer 2.
- Stats (macro defined):
  - Stimulus: 5 accepted requests.
  - Required: grant_count=5; after forcing the count to 16'hFFFE, two more grants leave it at 16'hFFFF.
